// File: rtl/clock_div_pkg.sv
// Shared constants and period-split helpers for the programmable clock divider.
// Pure package: no timing, no flow control.
package clock_div_pkg;

    localparam int CNT_W_DEF       = 8;
    localparam int DEFAULT_DIV_DEF = 8;
    localparam int DIV_MIN         = 2;

    // Divisors below DIV_MIN cannot produce both a low and a high phase.
    function automatic int clamp_div(input int d);
        return (d < DIV_MIN) ? DIV_MIN : d;
    endfunction

    // Low-phase length; the extra cycle of an odd period goes to the low phase.
    function automatic int calc_h(input int d);
        return d - (d / 2);
    endfunction

endpackage

// File: rtl/clock_div_prog_ch.sv
// One divider channel: counter, active/pending divisor, park control; outputs registered from next state.
// Latency: one iCLK from any input to clk_out/tick/running; divisor loads are never refused here.
module clock_div_prog_ch
    import clock_div_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic             iCLK,
    input  logic             RST,
    input  logic             en,
    input  logic             sync,
    input  logic             load,
    input  logic [CNT_W-1:0] load_div,
    output logic             clk_out,
    output logic             tick,
    output logic             running,
    output logic             pending
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] pend_div;

    logic [CNT_W-1:0] cnt_nx;
    logic [CNT_W-1:0] div_nx;
    logic [CNT_W-1:0] d_cur;
    logic [CNT_W-1:0] d_nx;
    logic [CNT_W-1:0] h_nx;
    logic             run_nx;
    logic             apply;

    always_comb begin
        d_cur  = CNT_W'(clamp_div(int'(div_q)));
        apply  = 1'b0;
        cnt_nx = cnt;
        run_nx = running;
        if (sync) begin
            apply  = 1'b1;
            cnt_nx = '0;
            run_nx = en;
        end else if (running) begin
            if (cnt == d_cur - 1'b1) begin
                apply  = 1'b1;
                cnt_nx = '0;
                run_nx = en;
            end else begin
                cnt_nx = cnt + 1'b1;
            end
        end else begin
            // Parked counts as cnt=0 of a new period, so starting jumps straight to 1.
            apply  = 1'b1;
            cnt_nx = en ? CNT_W'(1) : '0;
            run_nx = en;
        end
        div_nx = (apply && pending) ? pend_div : div_q;
        d_nx   = CNT_W'(clamp_div(int'(div_nx)));
        h_nx   = CNT_W'(calc_h(int'(d_nx)));
    end

    always_ff @(posedge iCLK or posedge RST) begin
        if (RST) begin
            cnt      <= '0;
            div_q    <= CNT_W'(DEFAULT_DIV);
            pend_div <= '0;
            pending  <= 1'b0;
            running  <= 1'b0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else begin
            cnt     <= cnt_nx;
            div_q   <= div_nx;
            running <= run_nx;
            clk_out <= (cnt_nx >= h_nx);
            tick    <= (cnt_nx == h_nx);
            // A load arriving on an apply cycle stays pending for the following boundary.
            if (load) begin
                pending  <= 1'b1;
                pend_div <= load_div;
            end else if (apply) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/clock_div_prog.sv
// NUM_CH glitch-free programmable dividers sharing one divisor-set handshake and a sync realign.
// Latency: one iCLK to outputs; cfg_ready stays low until every channel has applied its pending divisor.
module clock_div_prog
    import clock_div_pkg::*;
#(
    parameter int NUM_CH      = 2,
    parameter int CNT_W       = CNT_W_DEF,
    parameter int DEFAULT_DIV = DEFAULT_DIV_DEF
) (
    input  logic                    iCLK,
    input  logic                    RST,
    input  logic [NUM_CH-1:0]       en,
    input  logic                    sync,
    input  logic [NUM_CH*CNT_W-1:0] cfg_div,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       tick,
    output logic [NUM_CH-1:0]       running
);

    logic [NUM_CH-1:0] pending;
    logic              xfer;

    assign cfg_ready = ~|pending;
    assign xfer      = cfg_valid & cfg_ready;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clock_div_prog_ch #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_ch (
            .iCLK     (iCLK),
            .RST      (RST),
            .en       (en[i]),
            .sync     (sync),
            .load     (xfer),
            .load_div (cfg_div[i*CNT_W +: CNT_W]),
            .clk_out  (clk_out[i]),
            .tick     (tick[i]),
            .running  (running[i]),
            .pending  (pending[i])
        );
    end

endmodule

// File: tb/tb_clock_div_prog.sv
// Self-checking bench for clock_div_prog: directed scenarios plus random traffic against a
// period-position reference model (time since period start, compared with D and H).
module tb_clock_div_prog;

    localparam int NUM_CH = 2;
    localparam int CNT_W  = 8;

    logic                    iCLK = 1'b0;
    logic                    RST;
    logic [NUM_CH-1:0]       en;
    logic                    sync;
    logic [NUM_CH*CNT_W-1:0] cfg_div;
    logic                    cfg_valid;
    logic                    cfg_ready;
    logic [NUM_CH-1:0]       clk_out;
    logic [NUM_CH-1:0]       tick;
    logic [NUM_CH-1:0]       running;

    clock_div_prog #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DEFAULT_DIV(8)) dut (
        .iCLK      (iCLK),
        .RST       (RST),
        .en        (en),
        .sync      (sync),
        .cfg_div   (cfg_div),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .clk_out   (clk_out),
        .tick      (tick),
        .running   (running)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference model: each channel knows when its current period started and its length.
    int m_start [NUM_CH];
    int m_d     [NUM_CH];
    int m_pd    [NUM_CH];
    bit m_run   [NUM_CH];
    bit m_pend  [NUM_CH];
    logic [NUM_CH-1:0] e_clk, e_tick, e_run;
    logic              e_rdy;

    function automatic int clampd(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_start[c] = cyc; m_d[c] = 8; m_pd[c] = 0; m_run[c] = 0; m_pend[c] = 0;
        end
    endtask

    task automatic model_exp();
        bit any_p = 0;
        for (int c = 0; c < NUM_CH; c++) begin
            int pos = cyc - m_start[c];
            int h   = m_d[c] - m_d[c] / 2;
            e_clk[c]  = m_run[c] && (pos >= h);
            e_tick[c] = m_run[c] && (pos == h);
            e_run[c]  = m_run[c];
            any_p |= m_pend[c];
        end
        e_rdy = !any_p;
    endtask

    // Called at each active edge with the inputs that were presented to that edge.
    task automatic model_edge();
        bit any_p = 0;
        bit xfer;
        for (int c = 0; c < NUM_CH; c++) any_p |= m_pend[c];
        xfer = cfg_valid && !any_p;
        cyc++;
        for (int c = 0; c < NUM_CH; c++) begin
            bit apply = 0;
            if (sync) begin
                m_start[c] = cyc; m_run[c] = en[c]; apply = 1;
            end else if (m_run[c]) begin
                if (cyc - m_start[c] == m_d[c]) begin
                    apply = 1;
                    if (en[c]) m_start[c] = cyc;
                    else       m_run[c] = 0;
                end
            end else begin
                apply = 1;
                if (en[c]) begin m_run[c] = 1; m_start[c] = cyc - 1; end
            end
            if (apply && m_pend[c]) begin m_d[c] = m_pd[c]; m_pend[c] = 0; end
            if (xfer) begin
                m_pd[c]   = clampd(int'(cfg_div[c*CNT_W +: CNT_W]));
                m_pend[c] = 1;
            end
        end
        model_exp();
    endtask

    task automatic step();
        @(posedge iCLK);
        model_edge();
        #1;
        check_eq("clk_out", 32'(clk_out), 32'(e_clk));
        check_eq("tick", 32'(tick), 32'(e_tick));
        check_eq("running", 32'(running), 32'(e_run));
        check_eq("cfg_ready", 32'(cfg_ready), 32'(e_rdy));
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!cfg_ready && n < 64) begin step(); n++; end
        check_eq(tag, 32'(cfg_ready), 32'd1);
    endtask

    task automatic send_cfg(input logic [CNT_W-1:0] d1, input logic [CNT_W-1:0] d0);
        cfg_div   = {d1, d0};
        cfg_valid = 1'b1;
        step();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_pos0(input int p, input string tag);
        int n = 0;
        while (!(m_run[0] && (cyc - m_start[0] == p)) && n < 64) begin step(); n++; end
        check_eq(tag, 32'(m_run[0] && (cyc - m_start[0] == p)), 32'd1);
    endtask

    task automatic count_ticks(input int cycles, output int t0, output int t1);
        t0 = 0; t1 = 0;
        repeat (cycles) begin
            step();
            t0 += int'(tick[0]);
            t1 += int'(tick[1]);
        end
    endtask

    initial begin
        int t0, t1, n;
        bit found;
        RST = 1'b1; en = '0; sync = 1'b0; cfg_div = '0; cfg_valid = 1'b0;
        model_reset();
        #1;
        check_eq("rst_clk_out", 32'(clk_out), 32'd0);
        check_eq("rst_tick", 32'(tick), 32'd0);
        check_eq("rst_running", 32'(running), 32'd0);
        check_eq("rst_cfg_ready", 32'(cfg_ready), 32'd1);
        @(negedge iCLK);
        @(negedge iCLK);
        en  = 2'b11;
        RST = 1'b0;

        // Default divisor 8: first tick on the 4th edge, then every 8.
        count_ticks(24, t0, t1);
        check_eq("def_ticks_ch0", t0, 3);
        check_eq("def_ticks_ch1", t1, 3);

        // ch0=5, ch1=3 mid-period.
        repeat (2) step();
        send_cfg(8'd3, 8'd5);
        check_eq("cfg_ready_drop", 32'(cfg_ready), 32'd0);
        repeat (30) step();

        // 0 and 1 clamp to a period of 2.
        wait_ready("ready_before_clamp");
        send_cfg(8'd1, 8'd0);
        wait_ready("ready_after_clamp");
        count_ticks(10, t0, t1);
        check_eq("div2_ticks_ch0", t0, 5);
        check_eq("div2_ticks_ch1", t1, 5);

        // Back to 8, then drop en[0] at cnt=2: it finishes the period and parks.
        send_cfg(8'd8, 8'd8);
        wait_ready("ready_after_8");
        wait_pos0(2, "reach_cnt2");
        en[0] = 1'b0;
        repeat (6) step();
        check_eq("park_run0", 32'(running[0]), 32'd0);
        check_eq("park_clk0", 32'(clk_out[0]), 32'd0);
        check_eq("park_run1", 32'(running[1]), 32'd1);
        repeat (3) step();
        en[0] = 1'b1;
        repeat (12) step();

        // Put the channels out of phase, then realign with sync.
        en[1] = 1'b0;
        repeat (11) step();
        en[1] = 1'b1;
        repeat (5) step();
        sync = 1'b1;
        step();
        sync = 1'b0;
        check_eq("sync_low", 32'(clk_out), 32'd0);
        repeat (16) begin
            step();
            check_eq("sync_aligned", 32'(clk_out[0]), 32'(clk_out[1]));
        end

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 39) == 0) en[$urandom_range(0, NUM_CH-1)] ^= 1'b1;
            cfg_valid = ($urandom_range(0, 5) == 0);
            for (int c = 0; c < NUM_CH; c++) cfg_div[c*CNT_W +: CNT_W] = CNT_W'($urandom_range(0, 12));
            sync = ($urandom_range(0, 49) == 0);
            step();
        end
        cfg_valid = 1'b0; sync = 1'b0; en = 2'b11;
        repeat (30) step();

        // Async reset in ch0's high phase while a divisor set is pending.
        wait_ready("ready_before_rst");
        send_cfg(8'd8, 8'd8);
        wait_ready("ready_8_before_rst");
        wait_pos0(0, "reach_cnt0");
        send_cfg(8'd10, 8'd10);
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            step();
            found = e_clk[0] && m_pend[0];
            n++;
        end
        check_eq("find_high_pending", 32'(found), 32'd1);
        #2;
        RST = 1'b1;
        #1;
        model_reset();
        check_eq("arst_clk_out", 32'(clk_out), 32'd0);
        check_eq("arst_tick", 32'(tick), 32'd0);
        check_eq("arst_running", 32'(running), 32'd0);
        check_eq("arst_cfg_ready", 32'(cfg_ready), 32'd1);
        @(negedge iCLK);
        RST = 1'b0;
        count_ticks(16, t0, t1);
        check_eq("post_rst_ticks_ch0", t0, 2);
        check_eq("post_rst_ticks_ch1", t1, 2);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
